// File: rtl/sd_sector_copier.sv
// sd_sector_copier
//
// Moves N consecutive SD-card sectors into RAM with no CPU involvement.
// For each sector it writes the card address to the SD interface command
// register, reads that register back to launch the transfer, polls the status
// register until the 128-word sector buffer is full, then copies the buffer
// word by word to a destination region through a stallable memory port.
//
// Optional build macro: SD_COPY_CHECKSUM_EN adds oChecksum, the running
// mod-2^32 sum of every word written to memory.
//
// Ports
//   iCLK, Reset            clock; synchronous active-high reset
//   iStart                 one-cycle start pulse, ignored while oBusy
//   iCardAddr/iDstAddr     first card address / destination byte address
//   iSectorCount           number of sectors (0 completes at once)
//   oBusy, oDone, oError   status; oDone is a one-cycle pulse, oError is
//                          a sticky timeout flag cleared by the next start
//   oSD*                   SD bus master (read/write strobes, address, data)
//   iSDReadData            SD bus read data
//   oMem*                  memory write master
//   iMemWait               memory stall
//   oDbgState              current FSM state, for debug visibility
//   oChecksum              (SD_COPY_CHECKSUM_EN only) running data sum
//
// Bus semantics: every strobe is a single-cycle request that the slave takes
// on the rising edge where it is high. The SD side never stalls. A memory
// write is presented with oMemWriteEnable and is accepted on the first edge
// where iMemWait is low; until then address and data are held unchanged.
// SD and memory strobes are never high together.

module sd_sector_copier #(
    parameter logic [31:0] SD_CMD_ADDR  = 32'hFFFF0250,
    parameter logic [31:0] SD_CTRL_ADDR = 32'hFFFF0254,
    parameter logic [31:0] SD_BUF_BASE  = 32'hFFFF0050,
    parameter logic [31:0] SECTOR_STEP  = 32'd512,
    parameter logic [23:0] TIMEOUT      = 24'd1048575
) (
    input  logic        iCLK,
    input  logic        Reset,
    input  logic        iStart,
    input  logic [31:0] iCardAddr,
    input  logic [31:0] iDstAddr,
    input  logic [15:0] iSectorCount,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic        oSDReadEnable,
    output logic        oSDWriteEnable,
    output logic [31:0] oSDAddress,
    output logic [31:0] oSDWriteData,
    input  logic [31:0] iSDReadData,
    output logic        oMemWriteEnable,
    output logic [31:0] oMemAddress,
    output logic [31:0] oMemWriteData,
    input  logic        iMemWait,
`ifdef SD_COPY_CHECKSUM_EN
    output logic [31:0] oChecksum,
`endif
    output logic [2:0]  oDbgState
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_COPY_RD   = 3'd3,
        S_COPY_WR   = 3'd4,
        S_NEXT      = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] card_q, card_d;       // card address of the current sector
    logic [31:0] ptr_q, ptr_d;         // running destination pointer
    logic [15:0] remain_q, remain_d;   // sectors still to copy
    logic [6:0]  idx_q, idx_d;         // word index within the sector
    logic [23:0] tmo_q, tmo_d;         // wait-state cycle counter
    logic        first_q, first_d;     // first cycle of ISSUE or COPY_WR
    logic [31:0] wdata_q, wdata_d;     // captured buffer word
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] mem_wdata;
`ifdef SD_COPY_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    always_ff @(posedge iCLK) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            card_q   <= '0;
            ptr_q    <= '0;
            remain_q <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            first_q  <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef SD_COPY_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            card_q   <= card_d;
            ptr_q    <= ptr_d;
            remain_q <= remain_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            first_q  <= first_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef SD_COPY_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // The buffer word arrives on iSDReadData in the first COPY_WR cycle; it is
    // forwarded directly then and taken from the capture register while stalled.
    assign mem_wdata = first_q ? iSDReadData : wdata_q;

    always_comb begin
        state_d         = state_q;
        card_d          = card_q;
        ptr_d           = ptr_q;
        remain_d        = remain_q;
        idx_d           = idx_q;
        tmo_d           = tmo_q;
        first_d         = first_q;
        wdata_d         = wdata_q;
        done_d          = 1'b0;
        err_d           = err_q;
`ifdef SD_COPY_CHECKSUM_EN
        csum_d          = csum_q;
`endif
        oSDReadEnable   = 1'b0;
        oSDWriteEnable  = 1'b0;
        oSDAddress      = '0;
        oSDWriteData    = '0;
        oMemWriteEnable = 1'b0;
        oMemAddress     = '0;
        oMemWriteData   = '0;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    card_d   = iCardAddr;
                    ptr_d    = iDstAddr;
                    remain_d = iSectorCount;
                    idx_d    = '0;
                    err_d    = 1'b0;
`ifdef SD_COPY_CHECKSUM_EN
                    csum_d   = '0;
`endif
                    if (iSectorCount == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        first_d = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end

            S_ISSUE: begin
                // Write the card address, then read the command register back
                // until the interface reports busy (transfer under way).
                oSDAddress = SD_CMD_ADDR;
                if (first_q) begin
                    oSDWriteEnable = 1'b1;
                    oSDWriteData   = card_q;
                    first_d        = 1'b0;
                    tmo_d          = tmo_q + 24'd1;
                end else begin
                    oSDReadEnable = 1'b1;
                    if (iSDReadData != 32'd0) begin
                        state_d = S_WAIT_DONE;
                        tmo_d   = '0;
                    end else if (tmo_q == TIMEOUT) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 24'd1;
                    end
                end
            end

            S_WAIT_DONE: begin
                oSDReadEnable = 1'b1;
                oSDAddress    = SD_CTRL_ADDR;
                if (iSDReadData[3:0] == 4'd0) begin
                    state_d = S_COPY_RD;
                    idx_d   = '0;
                end else if (tmo_q == TIMEOUT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end

            S_COPY_RD: begin
                oSDReadEnable = 1'b1;
                oSDAddress    = SD_BUF_BASE + {23'd0, idx_q, 2'b00};
                state_d       = S_COPY_WR;
                first_d       = 1'b1;
            end

            S_COPY_WR: begin
                oMemWriteEnable = 1'b1;
                oMemAddress     = ptr_q;
                oMemWriteData   = mem_wdata;
                wdata_d         = mem_wdata;
                first_d         = 1'b0;
                if (!iMemWait) begin
                    ptr_d = ptr_q + 32'd4;
                    idx_d = idx_q + 7'd1;   // wraps to 0 after word 127
`ifdef SD_COPY_CHECKSUM_EN
                    csum_d = csum_q + mem_wdata;
`endif
                    state_d = (idx_q == 7'd127) ? S_NEXT : S_COPY_RD;
                end
            end

            S_NEXT: begin
                card_d   = card_q + SECTOR_STEP;
                remain_d = remain_q - 16'd1;
                if (remain_q == 16'd1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    first_d = 1'b1;
                    tmo_d   = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign oBusy     = (state_q != S_IDLE);
    assign oDone     = done_q;
    assign oError    = err_q;
    assign oDbgState = state_q;
`ifdef SD_COPY_CHECKSUM_EN
    assign oChecksum = csum_q;
`endif

endmodule
